// File: rtl/gen_dut.sv
// DDS sine generator: 32-bit phase accumulator, quarter-wave ROM, full-scale
// and amplitude-scaled outputs. The scaled output is gated by the enable,
// which is delayed to line up with the sample it qualifies.
module gen_dut #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 14
) (
  input  logic                     clk_125MHz,
  input  logic                     rst,
  input  logic                     en_gen,
  input  logic [PHASE_W-1:0]       cfg_data_0,
  input  logic [15:0]              cfg_amplitude,
  output logic signed [OUT_W-1:0]  Out_1,
  output logic signed [OUT_W-1:0]  Out_axis_zeroer
);

  localparam int MAG_W     = OUT_W - 1;               // table magnitude width
  localparam int LUT_N     = (1 << LUT_AW) + 1;       // quarter wave incl. both ends
  localparam int FULL      = (1 << (OUT_W - 1)) - 1;  // 8191
  localparam int AMP_W     = 17;                      // {0, cfg_amplitude}
  localparam int PROD_W    = OUT_W + AMP_W;           // 31
  localparam int SCL_W     = PROD_W - (OUT_W - 1);    // product >>> 13
  localparam int EN_STAGES = 4;

  localparam logic [LUT_AW:0]            QTR     = {1'b1, {LUT_AW{1'b0}}};
  localparam logic signed [SCL_W-1:0]    POS_LIM = SCL_W'(FULL);
  localparam logic signed [SCL_W-1:0]    NEG_LIM = -SCL_W'(FULL);
  localparam logic signed [OUT_W-1:0]    OUT_MAX = OUT_W'(FULL);
  localparam logic signed [OUT_W-1:0]    OUT_MIN = -OUT_W'(FULL);

  // round(FULL * sin(pi/2 * k / 2^LUT_AW)), evaluated at elaboration only.
  // A Taylor series keeps this free of $sin; 12 terms is far below 1 LSB.
  function automatic logic [MAG_W-1:0] quarter_sin(input int k);
    real x, term, s;
    x    = 1.5707963267948966 * real'(k) / real'(1 << LUT_AW);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return MAG_W'($rtoi(real'(FULL) * s + 0.5));
  endfunction

  logic [MAG_W-1:0] rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [MAG_W-1:0] VAL = quarter_sin(k);
    assign rom[k] = VAL;
  end

  logic [PHASE_W-1:0]       acc_d,     acc_q;
  logic signed [OUT_W-1:0]  sine_d,    sine_q;
  logic signed [OUT_W-1:0]  out1_d,    out1_q;
  logic signed [SCL_W-1:0]  scaled_d,  scaled_q;
  logic signed [OUT_W-1:0]  axis_d,    axis_q;
  logic [EN_STAGES-1:0]     en_pipe_d, en_pipe_q;

  logic [1:0]               quad;
  logic [LUT_AW-1:0]        idx;
  logic [LUT_AW:0]          addr;
  logic [MAG_W-1:0]         mag;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  sat;

  // Next-state for all stages: accumulate, fold the quadrant, scale, clip, gate
  always_comb begin
    // Disabled accumulator parks at 0 so each enable restarts at phase 0
    acc_d     = en_gen ? acc_q + cfg_data_0 : '0;
    en_pipe_d = {en_pipe_q[EN_STAGES-2:0], en_gen};

    // Odd quadrants walk the table backwards; upper half negates
    quad   = acc_q[PHASE_W-1 -: 2];
    idx    = acc_q[PHASE_W-3 -: LUT_AW];
    addr   = quad[0] ? QTR - {1'b0, idx} : {1'b0, idx};
    mag    = rom[addr];
    sine_d = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

    out1_d = sine_q;

    // Unity gain sits at amplitude 2^13, so dropping 13 LSBs is the >>> 13
    prod     = out1_q * $signed({1'b0, cfg_amplitude});
    scaled_d = prod[PROD_W-1 -: SCL_W];

    if (scaled_q > POS_LIM)      sat = OUT_MAX;
    else if (scaled_q < NEG_LIM) sat = OUT_MIN;
    else                         sat = scaled_q[OUT_W-1:0];
    axis_d = en_pipe_q[EN_STAGES-1] ? sat : '0;
  end

  // Pipeline registers, all cleared by the asynchronous reset
  always_ff @(posedge clk_125MHz or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      sine_q    <= '0;
      out1_q    <= '0;
      scaled_q  <= '0;
      axis_q    <= '0;
      en_pipe_q <= '0;
    end else begin
      acc_q     <= acc_d;
      sine_q    <= sine_d;
      out1_q    <= out1_d;
      scaled_q  <= scaled_d;
      axis_q    <= axis_d;
      en_pipe_q <= en_pipe_d;
    end
  end

  assign Out_1           = out1_q;
  assign Out_axis_zeroer = axis_q;

endmodule

// File: tb/tb_gen_dut.sv
// Directed bench for the DDS generator: reset, quadrant sequence, 5 MHz and
// 2.5 MHz tones, enable gating, saturation and zero amplitude.
module tb_gen_dut;

  logic               clk_125MHz = 1'b0;
  logic               rst;
  logic               en_gen;
  logic [31:0]        cfg_data_0;
  logic [15:0]        cfg_amplitude;
  logic signed [13:0] Out_1;
  logic signed [13:0] Out_axis_zeroer;

  int n_chk = 0;
  int n_err = 0;
  int o1 [0:127];
  int ax [0:127];

  // Quadrant-increment sequences worked out by hand
  localparam int QS     [4] = '{0, 8191, 0, -8191};    // Out_1, full scale
  localparam int QA     [4] = '{0, 1023, 0, -1024};    // amp 1024: floor(+-8191*1024/8192)
  localparam int QSAT   [4] = '{0, 8191, 0, -8191};    // amp 65535, clipped
  localparam int DIS_AX [8] = '{0, -1024, 0, 1023, 0, 0, 0, 0};
  localparam int DIS_O1 [8] = '{0, 8191, 0, 0, 0, 0, 0, 0};

  always #4 clk_125MHz = ~clk_125MHz;

  gen_dut dut (
    .clk_125MHz      (clk_125MHz),
    .rst             (rst),
    .en_gen          (en_gen),
    .cfg_data_0      (cfg_data_0),
    .cfg_amplitude   (cfg_amplitude),
    .Out_1           (Out_1),
    .Out_axis_zeroer (Out_axis_zeroer)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125MHz);
    #1;
  endtask

  task automatic drain();
    en_gen = 1'b0;
    repeat (8) tick();
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  initial begin
    int bad, mx, mn, omx, omn;

    // Reset held with the generator enabled and configured
    rst           = 1'b0;
    en_gen        = 1'b1;
    cfg_data_0    = 32'h4000_0000;
    cfg_amplitude = 16'd1024;
    repeat (4) tick();
    chk("rst_o1", Out_1, 0);
    chk("rst_ax", Out_axis_zeroer, 0);
    en_gen = 1'b0;
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("idle_o1", Out_1, 0);
    chk("idle_ax", Out_axis_zeroer, 0);

    // Quadrant walk: increment 2^30, amplitude 1024
    en_gen = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("quad_o1[%0d]", k), Out_1, (k < 2) ? 0 : QS[(k - 2) % 4]);
      chk($sformatf("quad_ax[%0d]", k), Out_axis_zeroer, (k < 5) ? 0 : QA[(k - 4) % 4]);
    end
    // Drop enable: four in-flight samples still emerge, then zero exactly
    en_gen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("dis_ax[%0d]", j), Out_axis_zeroer, DIS_AX[j]);
      chk($sformatf("dis_o1[%0d]", j), Out_1, DIS_O1[j]);
    end

    // 5 MHz tone, amplitude 1024
    cfg_data_0    = 32'd171798691;
    cfg_amplitude = 16'd1024;
    en_gen        = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      tick();
      o1[k] = Out_1;
      ax[k] = Out_axis_zeroer;
    end
    chk("5m_o1_lat", o1[2], 0);
    chk("5m_o1_first", o1[3], 1990);     // T[40]
    chk("5m_ax_lat", ax[4], 0);
    chk("5m_ax_first", ax[5], 248);      // floor(1990*1024/8192)
    bad = 0;
    for (int k = 5; k <= 28; k++) if (ax[k] != ax[k + 25]) bad++;
    chk("5m_period25", bad, 0);
    mx = -99999; mn = 99999; omx = -99999; omn = 99999;
    for (int k = 5; k <= 54; k++) begin
      if (ax[k] > mx) mx = ax[k];
      if (ax[k] < mn) mn = ax[k];
      if (o1[k - 2] > omx) omx = o1[k - 2];
      if (o1[k - 2] < omn) omn = o1[k - 2];
    end
    chk("5m_ax_max", int'(mx >= 1015 && mx <= 1023), 1);
    chk("5m_ax_min", int'(mn <= -1015 && mn >= -1024), 1);
    chk("5m_o1_max", int'(omx >= 8150 && omx <= 8191), 1);
    chk("5m_o1_min", int'(omn <= -8150 && omn >= -8191), 1);

    // Disable and retune to 2.5 MHz, amplitude 500
    en_gen        = 1'b0;
    cfg_data_0    = 32'd85899345;
    cfg_amplitude = 16'd500;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j >= 5) chk($sformatf("off_ax[%0d]", j), Out_axis_zeroer, 0);
      if (j >= 3) chk($sformatf("off_o1[%0d]", j), Out_1, 0);
    end
    en_gen = 1'b1;
    for (int k = 1; k <= 104; k++) begin
      tick();
      o1[k] = Out_1;
      ax[k] = Out_axis_zeroer;
    end
    chk("rt_ax_lat", ax[4], 0);
    chk("rt_ax_first", ax[5], 61);       // T[20]=1003 -> floor(1003*500/8192)
    bad = 0;
    for (int k = 5; k <= 53; k++) if (ax[k] != ax[k + 50]) bad++;
    chk("rt_period50", bad, 0);
    mx = -99999; mn = 99999;
    for (int k = 5; k <= 104; k++) begin
      if (ax[k] > mx) mx = ax[k];
      if (ax[k] < mn) mn = ax[k];
    end
    chk("rt_ax_max", int'(mx >= 490 && mx <= 500), 1);
    chk("rt_ax_min", int'(mn <= -490 && mn >= -500), 1);

    // Saturation: amplitude 65535 clips to +-8191
    drain();
    cfg_data_0    = 32'h4000_0000;
    cfg_amplitude = 16'hFFFF;
    en_gen        = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("sat_ax[%0d]", k), Out_axis_zeroer, (k < 5) ? 0 : QSAT[(k - 4) % 4]);
    end
    cfg_data_0 = 32'd171798691;
    for (int k = 1; k <= 40; k++) begin
      tick();
      o1[k] = Out_1;
      ax[k] = Out_axis_zeroer;
    end
    bad = 0; mx = -99999; mn = 99999;
    for (int k = 3; k <= 40; k++) begin
      if (sgn(ax[k]) != sgn(o1[k - 2])) bad++;
      if (ax[k] < -8191) bad++;
      if (ax[k] > mx) mx = ax[k];
      if (ax[k] < mn) mn = ax[k];
    end
    chk("sat_sign", bad, 0);
    chk("sat_peak", int'(mx == 8191 && mn == -8191), 1);

    // Zero amplitude: scaled output stays 0, full-scale keeps running
    drain();
    cfg_data_0    = 32'h4000_0000;
    cfg_amplitude = 16'd0;
    en_gen        = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("zamp_ax[%0d]", k), Out_axis_zeroer, 0);
      chk($sformatf("zamp_o1[%0d]", k), Out_1, (k < 2) ? 0 : QS[(k - 2) % 4]);
    end

    // Asynchronous reset between clock edges clears Out_1 (currently 8191)
    rst = 1'b0;
    #1;
    chk("async_o1", Out_1, 0);
    chk("async_ax", Out_axis_zeroer, 0);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gen_dut.md
Name: gen_dut

Overview:
- Direct digital synthesis (DDS) sine generator for the 125 MHz DAC path.
- A 32-bit phase accumulator drives a quarter-wave sine table.
- Out_1 carries the full-scale sine.
- Out_axis_zeroer carries the amplitude-scaled sine, forced to zero whenever the generator is disabled.
- Sits between the configuration registers (cfg_data_0, cfg_amplitude, en_gen) and the DAC/AXIS output stage.

Parameters:
- PHASE_W, 32, phase accumulator and increment width.
- LUT_AW, 8, quarter-wave table index width (table has 2^LUT_AW+1 = 257 entries).
- OUT_W, 14, output sample width (signed two's complement).

Ports:
- clk_125MHz  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- en_gen  input  1  generator enable, level sensitive.
- cfg_data_0  input  32  phase increment per clock; f_out = cfg_data_0 × 125e6 / 2^32.
- cfg_amplitude  input  16  unsigned output peak amplitude in DAC codes.
- Out_1  output  14  signed full-scale sine (±8191).
- Out_axis_zeroer  output  14  signed amplitude-scaled sine; 0 when disabled.

Behaviour:
- Reset (rst=0, asynchronous) clears the accumulator, every pipeline register, Out_1 and Out_axis_zeroer to 0. Release is synchronous to the next edge.
- Inputs are sampled every clock; configuration changes take effect without restart.
- Stage 0 (accumulator):
  - en_gen=1: acc <= acc + cfg_data_0, wrapping mod 2^32.
  - en_gen=0: acc <= 0, so each enable restarts the waveform at phase 0.
- Stage 1 (table lookup):
  - Quadrant q = acc[31:30]; index i = acc[29:22].
  - Table T[k] = round(8191·sin(π/2·k/256)) for k = 0..256; T[0]=0, T[256]=8191.
  - q0 → T[i]; q1 → T[256−i]; q2 → −T[i]; q3 → −T[256−i].
  - The result is registered as the sine sample.
- Stage 2: Out_1 <= sine sample. Latency from the accumulator register to Out_1 is 2 clocks.
- Stage 3 (scaling):
  - prod = sine (signed 14-bit) × {0, cfg_amplitude} (signed 17-bit), a 31-bit signed product.
  - scaled = prod >>> 13 (arithmetic shift, truncation toward −inf).
- Stage 4 (output):
  - Saturate scaled to [−8191, +8191].
  - Out_axis_zeroer <= en_d ? saturated value : 0.
  - en_d is en_gen delayed to align with the sample (4-stage enable pipeline).
- When en_gen drops, Out_axis_zeroer goes to 0 exactly when the first disabled-phase sample arrives, with no partial stale samples.
- Out_1 is not gated. While disabled it shows sin(0)=0 once the pipeline drains.
- Amplitude semantics: the peak output is ≈ cfg_amplitude.
  - Example: 1024 → ±1023.
  - cfg_amplitude ≥ 8192 saturates at ±8191.
  - cfg_amplitude = 0 → constant 0.
- cfg_data_0 = 0 holds a constant phase.
- cfg_data_0 ≥ 2^31 aliases; no error flag.
- Table is a synthesizable case/ROM. No block-RAM read-enable requirement.

Test Plan:
- Reset: hold rst=0 with en_gen=1 and nonzero config → Out_1=0 and Out_axis_zeroer=0. After release with en_gen=0 → both stay 0.
- 5 MHz: cfg_data_0=171798691, cfg_amplitude=1024, assert en_gen=1 →
  - Out_axis_zeroer is periodic with 25-cycle period and peaks within ±1023 (max ≥1015, min ≤−1015).
  - Out_1 peaks within ±8191 (≥8150).
  - First nonzero sample appears at the documented latency.
- Disable/retune: drop en_gen, set cfg_data_0=85899345 and cfg_amplitude=500, re-enable →
  - Out_axis_zeroer is 0 while disabled.
  - After re-enable the wave restarts from 0 with a 50-cycle period and peak ±499/500.
- Saturation: cfg_amplitude=65535 with any nonzero increment → Out_axis_zeroer is clipped to ±8191 and never wraps sign.
- Zero amplitude: cfg_amplitude=0 with en_gen=1 → Out_axis_zeroer=0 every cycle while Out_1 still toggles full-scale.
- Quadrant check: cfg_data_0=2^30 (four-sample period) → Out_1 sequence 0, 8191, 0, −8191 repeating.
